pip_hazard_ctrl: RTL

Pipeline control unit for the 5-stage lab pipeline (IF, ID, EX, MEM, WB). It drives the we/srst_n pair of every pipeline register and the PC write enable. It resolves four conditions: load-use hazards, taken-branch flushes, multi-cycle EX multiplies, and data-memory wait states. It also keeps a saturating stall-cycle counter for performance measurement.

---
 rtl/pip_pkg.sv | 41 ++++
 rtl/pip_stall_cnt.sv | 19 +
 rtl/pip_hazard_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/pip_pkg.sv
// Shared types for the 5-stage pipeline hazard controller: FSM encoding and
// per-register control actions with their priority-row vectors.
package pip_pkg;

  localparam int RF_AW = 5;

  typedef enum logic {
    RUN      = 1'b0,
    MUL_WAIT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    ADV    = 2'd1,
    BUBBLE = 2'd2
  } reg_ctl_e;

  typedef struct packed {
    reg_ctl_e pc;
    reg_ctl_e ifid;
    reg_ctl_e idex;
    reg_ctl_e exmem;
    reg_ctl_e memwb;
  } ctl_vec_t;

  localparam ctl_vec_t CTL_MEM_STALL = '{pc: HOLD, ifid: HOLD,   idex: HOLD,   exmem: HOLD,   memwb: BUBBLE};
  localparam ctl_vec_t CTL_MUL_STALL = '{pc: HOLD, ifid: HOLD,   idex: HOLD,   exmem: BUBBLE, memwb: ADV};
  localparam ctl_vec_t CTL_BRANCH    = '{pc: ADV,  ifid: BUBBLE, idex: BUBBLE, exmem: ADV,    memwb: ADV};
  localparam ctl_vec_t CTL_LOAD_USE  = '{pc: HOLD, ifid: HOLD,   idex: BUBBLE, exmem: ADV,    memwb: ADV};
  localparam ctl_vec_t CTL_RUN       = '{pc: ADV,  ifid: ADV,    idex: ADV,    exmem: ADV,    memwb: ADV};

  // A flush must still assert we, because srst_n is ignored while holding.
  function automatic logic ctl_we(input reg_ctl_e c);
    return c != HOLD;
  endfunction

  function automatic logic ctl_srst_n(input reg_ctl_e c);
    return c != BUBBLE;
  endfunction

endpackage

// File: rtl/pip_stall_cnt.sv
// Saturating up-counter used for the stall-cycle performance counter.
module pip_stall_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      count <= '0;
    end else if (inc && count != '1) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pip_hazard_ctrl.sv
// Hazard/stall controller for the IF-ID-EX-MEM-WB pipeline: load-use, branch
// flush, multi-cycle multiply and data-memory wait, plus a stall counter.
module pip_hazard_ctrl #(
  parameter int RF_AW   = pip_pkg::RF_AW,
  parameter int MUL_CYC = 4,
  parameter int PERF_W  = 16
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic [RF_AW-1:0]  id_rs,
  input  logic [RF_AW-1:0]  id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [RF_AW-1:0]  ex_rd,
  input  logic              ex_memread,
  input  logic              ex_mul,
  input  logic              ex_branch_taken,
  input  logic              dmem_req,
  input  logic              dmem_ack,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              ifid_srst_n,
  output logic              idex_we,
  output logic              idex_srst_n,
  output logic              exmem_we,
  output logic              exmem_srst_n,
  output logic              memwb_we,
  output logic              memwb_srst_n,
  output logic              mul_busy,
  output logic [PERF_W-1:0] stall_cycles
);

  import pip_pkg::*;

  localparam int MUL_CNT_W = (MUL_CYC > 2) ? $clog2(MUL_CYC) : 1;
  localparam logic [MUL_CNT_W-1:0] MUL_LOAD = (MUL_CYC >= 2) ? MUL_CNT_W'(MUL_CYC - 2) : '0;
  localparam bit MUL_STALLS = (MUL_CYC > 1);

  state_e               state_q, state_d;
  logic [MUL_CNT_W-1:0] mul_cnt_q, mul_cnt_d;
  ctl_vec_t             ctl;
  logic                 mem_stall, mul_stall, load_use;

  assign mem_stall = dmem_req & ~dmem_ack;
  assign mul_stall = ex_mul & MUL_STALLS & ((state_q == RUN) | (mul_cnt_q != '0));
  assign load_use  = ex_memread & (ex_rd != '0) &
                     ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= RUN;
      mul_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

  // NOTE: defaults first so no path through this block leaves a latch.
  always_comb begin
    state_d   = state_q;
    mul_cnt_d = mul_cnt_q;
    if (!mem_stall) begin
      unique case (state_q)
        RUN: begin
          if (mul_stall) begin
            state_d   = MUL_WAIT;
            mul_cnt_d = MUL_LOAD;
          end
        end
        MUL_WAIT: begin
          if (mul_cnt_q != '0) mul_cnt_d = mul_cnt_q - MUL_CNT_W'(1);
          else                 state_d   = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Exactly one priority row applies; a branch under a stall waits its turn.
  always_comb begin
    ctl = CTL_RUN;
    if      (mem_stall)       ctl = CTL_MEM_STALL;
    else if (mul_stall)       ctl = CTL_MUL_STALL;
    else if (ex_branch_taken) ctl = CTL_BRANCH;
    else if (load_use)        ctl = CTL_LOAD_USE;
  end

  assign pc_we        = ctl_we(ctl.pc);
  assign ifid_we      = ctl_we(ctl.ifid);
  assign ifid_srst_n  = ctl_srst_n(ctl.ifid);
  assign idex_we      = ctl_we(ctl.idex);
  assign idex_srst_n  = ctl_srst_n(ctl.idex);
  assign exmem_we     = ctl_we(ctl.exmem);
  assign exmem_srst_n = ctl_srst_n(ctl.exmem);
  assign memwb_we     = ctl_we(ctl.memwb);
  assign memwb_srst_n = ctl_srst_n(ctl.memwb);
  assign mul_busy     = (state_q == MUL_WAIT);

  pip_stall_cnt #(.W(PERF_W)) u_stall_cnt (
    .clk    (clk),
    .arst_n (arst_n),
    .inc    (~pc_we),
    .count  (stall_cycles)
  );

endmodule
